// File: rtl/lcd_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_scanout
//  Purpose  : Panel timing generator and line-buffer pixel scan-out with
//             per-line fetch requests to the framebuffer DMA.
//             Optional build macro LCD_TEST_PATTERN_EN adds colour-bar output.
//  Revision : 1.0  initial release
// ============================================================================

package lcd;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color;
endpackage

module lcd_scanout #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
`ifdef LCD_TEST_PATTERN_EN
    input  logic        pattern_en,
`endif
    output logic [9:0]  buffer_addr,
    output logic        buffer_clk,
    input  lcd::color   buffer_data,
    output logic [8:0]  row,
    output logic        hsync,
    output logic        lcd_dclk,
    output logic        lcd_de,
    output logic        lcd_hsync_n,
    output logic        lcd_vsync_n,
    output logic [7:0]  lcd_r,
    output logic [7:0]  lcd_g,
    output logic [7:0]  lcd_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] v_next;
    logic          tick;
    logic          h_wrap;
    logic          h_act;
    logic          v_act;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          fetch;

    // First pipeline stage: region flags of the pixel whose address was just issued
    logic          de_p;
    logic          hs_p;
    logic          vs_p;
    lcd::color     pix;

    assign buffer_clk = clk;

    assign tick      = (div == '0);
    assign h_wrap    = (hcnt == H_LAST);
    assign v_next    = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    assign h_act     = (hcnt < H_ACT_END);
    assign v_act     = (vcnt < V_ACT_END);
    assign h_in_sync = (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
    assign v_in_sync = (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);
    assign fetch     = tick && (hcnt == H_ACT_END) && (v_next < V_ACT_END);

`ifdef LCD_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [2:0] bar;
    lcd::color  bar_color;

    // White, yellow, cyan, green, magenta, red, blue, black
    assign bar         = 3'(buffer_addr / 10'(BAR_W));
    assign bar_color.r = {8{~bar[1]}};
    assign bar_color.g = {8{~bar[2]}};
    assign bar_color.b = {8{~bar[0]}};
`endif

    always_comb begin
        pix = buffer_data;
`ifdef LCD_TEST_PATTERN_EN
        if (pattern_en) begin
            pix = bar_color;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else if (!en) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (tick) begin
                hcnt <= h_wrap ? '0 : hcnt + 1'b1;
                if (h_wrap) begin
                    vcnt <= v_next;
                end
            end
        end
    end

    // Fetch request and line-buffer addressing; row and address hold while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_addr <= '0;
            row         <= '0;
            hsync       <= 1'b0;
            lcd_dclk    <= 1'b0;
        end else if (!en) begin
            hsync       <= 1'b0;
            lcd_dclk    <= 1'b0;
        end else begin
            lcd_dclk <= (div >= DIV_HALF);
            hsync    <= fetch;
            if (fetch) begin
                row <= 9'(v_next);
            end
            if (tick && h_act) begin
                buffer_addr <= 10'(hcnt);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_p        <= 1'b0;
            hs_p        <= 1'b0;
            vs_p        <= 1'b0;
            lcd_de      <= 1'b0;
            lcd_hsync_n <= 1'b1;
            lcd_vsync_n <= 1'b1;
            lcd_r       <= 8'h00;
            lcd_g       <= 8'h00;
            lcd_b       <= 8'h00;
        end else if (!en) begin
            de_p        <= 1'b0;
            hs_p        <= 1'b0;
            vs_p        <= 1'b0;
            lcd_de      <= 1'b0;
            lcd_hsync_n <= 1'b1;
            lcd_vsync_n <= 1'b1;
            lcd_r       <= 8'h00;
            lcd_g       <= 8'h00;
            lcd_b       <= 8'h00;
        end else if (tick) begin
            de_p        <= h_act && v_act;
            hs_p        <= h_in_sync;
            vs_p        <= v_in_sync;
            lcd_de      <= de_p;
            lcd_hsync_n <= !hs_p;
            lcd_vsync_n <= !vs_p;
            lcd_r       <= de_p ? pix.r : 8'h00;
            lcd_g       <= de_p ? pix.g : 8'h00;
            lcd_b       <= de_p ? pix.b : 8'h00;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_scanout
//  Purpose  : Self-checking bench for lcd_scanout on a reduced panel geometry.
//  Revision : 1.0  initial release
// ============================================================================

module tb_lcd_scanout;

    localparam int CD    = 2;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int HBP   = 2;
    localparam int VA    = 6;
    localparam int VFP   = 1;
    localparam int VSW   = 2;
    localparam int VBP   = 1;
    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
`ifdef LCD_TEST_PATTERN_EN
    localparam bit PAT_BUILD = 1'b1;
`else
    localparam bit PAT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pattern_en;
    logic [9:0]  buffer_addr;
    logic        buffer_clk;
    lcd::color   buffer_data;
    logic [8:0]  row;
    logic        hsync;
    logic        lcd_dclk;
    logic        lcd_de;
    logic        lcd_hsync_n;
    logic        lcd_vsync_n;
    logic [7:0]  lcd_r;
    logic [7:0]  lcd_g;
    logic [7:0]  lcd_b;

    lcd_scanout #(
        .CLK_DIV  (CD),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HSW),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSW),
        .V_BP     (VBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef LCD_TEST_PATTERN_EN
        .pattern_en  (pattern_en),
`endif
        .buffer_addr (buffer_addr),
        .buffer_clk  (buffer_clk),
        .buffer_data (buffer_data),
        .row         (row),
        .hsync       (hsync),
        .lcd_dclk    (lcd_dclk),
        .lcd_de      (lcd_de),
        .lcd_hsync_n (lcd_hsync_n),
        .lcd_vsync_n (lcd_vsync_n),
        .lcd_r       (lcd_r),
        .lcd_g       (lcd_g),
        .lcd_b       (lcd_b)
    );

    always #5 clk = ~clk;

    // Line buffer: random contents, one-clock synchronous read
    logic [23:0] mem [1024];
    always @(posedge clk) buffer_data <= mem[buffer_addr];

    logic [23:0] bars [8];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: n = clocks since timing origin, t = pixel ticks since origin.
    // Pixel tick k sits at frame position k mod FRAME; panel pins show position k-1.
    int          n, t, p, h, v, q, qh, qv;
    int          m_addr, m_row;
    bit          m_hsync, m_dclk, m_de, m_hs_n, m_vs_n;
    logic [23:0] m_rgb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0; t = 0; m_addr = 0; m_row = 0;
            m_hsync = 0; m_dclk = 0; m_de = 0; m_hs_n = 1; m_vs_n = 1; m_rgb = '0;
        end else if (!en) begin
            n = 0; t = 0;
            m_hsync = 0; m_dclk = 0; m_de = 0; m_hs_n = 1; m_vs_n = 1; m_rgb = '0;
        end else begin
            m_dclk  = (n % CD) >= (CD / 2);
            m_hsync = 0;
            if (n % CD == 0) begin
                p = t % FRAME;
                h = p % HT;
                v = p / HT;
                if (t == 0) begin
                    m_de = 0; m_hs_n = 1; m_vs_n = 1; m_rgb = '0;
                end else begin
                    q  = (t - 1) % FRAME;
                    qh = q % HT;
                    qv = q / HT;
                    m_de   = (qh < HA) && (qv < VA);
                    m_hs_n = !((qh >= HA + HFP) && (qh < HA + HFP + HSW));
                    m_vs_n = !((qv >= VA + VFP) && (qv < VA + VFP + VSW));
                    if (!m_de)
                        m_rgb = '0;
                    else if (PAT_BUILD && pattern_en)
                        m_rgb = bars[qh / (HA / 8)];
                    else
                        m_rgb = mem[qh];
                end
                if (h < HA) m_addr = h;
                if (h == HA && ((v + 1) % VT) < VA) begin
                    m_row   = (v + 1) % VT;
                    m_hsync = 1;
                end
                t++;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        check("addr",    32'(buffer_addr), 32'(m_addr));
        check("row",     32'(row),         32'(m_row));
        check("hsync",   32'(hsync),       32'(m_hsync));
        check("dclk",    32'(lcd_dclk),    32'(m_dclk));
        check("de",      32'(lcd_de),      32'(m_de));
        check("hsync_n", 32'(lcd_hsync_n), 32'(m_hs_n));
        check("vsync_n", 32'(lcd_vsync_n), 32'(m_vs_n));
        check("rgb",     32'({lcd_r, lcd_g, lcd_b}), 32'(m_rgb));
    end

    typedef struct {
        logic en;
        logic pat;
        int   clks;
        int   pulses;
        int   de_clks;
        int   hs_low;
        int   vs_low;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, pulses, de_c, hs_l, vs_l;
        bit found;

        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);

        vecs[0] = '{1'b0, 1'b0, 7,            0,      0,                0,                  0};
        vecs[1] = '{1'b1, 1'b0, 2*FRAME*CD,   2*VA,   2*HA*VA*CD,       2*HSW*VT*CD,        2*VSW*HT*CD};
        vecs[2] = '{1'b0, 1'b0, 3,            0,      0,                0,                  0};
        vecs[3] = '{1'b1, 1'b1, FRAME*CD,     VA,     HA*VA*CD,         HSW*VT*CD,          VSW*HT*CD};
        vecs[4] = '{1'b0, 1'b0, 5,            0,      0,                0,                  0};
        vecs[5] = '{1'b1, 1'b0, FRAME*CD,     VA,     HA*VA*CD,         HSW*VT*CD,          VSW*HT*CD};

        rst = 1'b1; en = 1'b1; pattern_en = 1'b0;
        @(negedge clk);
        check("rst_addr",    32'(buffer_addr), 0);
        check("rst_row",     32'(row),         0);
        check("rst_hsync",   32'(hsync),       0);
        check("rst_dclk",    32'(lcd_dclk),    0);
        check("rst_de",      32'(lcd_de),      0);
        check("rst_hsync_n", 32'(lcd_hsync_n), 1);
        check("rst_vsync_n", 32'(lcd_vsync_n), 1);
        check("rst_rgb",     32'({lcd_r, lcd_g, lcd_b}), 0);
        rst = 1'b0;

        // First vertical sync after release, counted in clocks
        cnt = 0; found = 0;
        for (int k = 0; k < 4 * FRAME * CD && !found; k++) begin
            @(negedge clk);
            cnt++;
            if (lcd_vsync_n === 1'b0) found = 1;
        end
        check("vsync_fall_clks", 32'(cnt), 32'(((VA + VFP) * HT + 1) * CD + 1));

        for (int i = 0; i < 6; i++) begin
            en = vecs[i].en;
            pattern_en = vecs[i].pat;
            pulses = 0; de_c = 0; hs_l = 0; vs_l = 0;
            repeat (vecs[i].clks) begin
                @(negedge clk);
                if (hsync === 1'b1) pulses++;
                if (lcd_de === 1'b1) de_c++;
                if (lcd_hsync_n === 1'b0) hs_l++;
                if (lcd_vsync_n === 1'b0) vs_l++;
            end
            check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].pulses));
            check($sformatf("vec%0d_de", i),     32'(de_c),   32'(vecs[i].de_clks));
            check($sformatf("vec%0d_hs_low", i), 32'(hs_l),   32'(vecs[i].hs_low));
            check($sformatf("vec%0d_vs_low", i), 32'(vs_l),   32'(vecs[i].vs_low));
        end
        pattern_en = 1'b0;

        // Drop enable with counters at (h=5, v=3), mid visible line
        found = 0;
        for (int k = 0; k < 2 * FRAME * CD && !found; k++) begin
            if ((t % FRAME) == 3 * HT + 5) found = 1;
            else @(negedge clk);
        end
        check("drop_reached", 32'(found), 1);
        en = 1'b0;
        @(negedge clk);
        check("drop_de",      32'(lcd_de),      0);
        check("drop_hsync_n", 32'(lcd_hsync_n), 1);
        check("drop_vsync_n", 32'(lcd_vsync_n), 1);
        check("drop_rgb",     32'({lcd_r, lcd_g, lcd_b}), 0);
        check("drop_dclk",    32'(lcd_dclk),    0);
        check("drop_row",     32'(row),         3);
        repeat (4) @(negedge clk);
        en = 1'b1;
        cnt = 0; found = 0;
        for (int k = 0; k < 10 * CD && !found; k++) begin
            @(negedge clk);
            cnt++;
            if (lcd_de === 1'b1) found = 1;
        end
        check("restart_de_clks", 32'(cnt), 32'(CD + 1));
        check("restart_row",     32'(row), 3);

        // Random enable / pattern toggling with one asynchronous reset
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) en = !en;
            if ($urandom_range(0, 199) == 0) pattern_en = !pattern_en;
            if (k == 1500) begin
                en = 1'b1;
                #2 rst = 1'b1;
                #1;
                check("arst_hsync",   32'(hsync),       0);
                check("arst_de",      32'(lcd_de),      0);
                check("arst_hsync_n", 32'(lcd_hsync_n), 1);
                check("arst_row",     32'(row),         0);
            end
            if (k == 1501) rst = 1'b0;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
